// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and default parameters for the fetch sequencer
// Purpose: FSM state enum plus default widths, PC increment and ack timeout.
// Ports: none (package).
package fetch_pkg;

   localparam int ADDR_W_DEF   = 20;
   localparam int DATA_W_DEF   = 32;
   localparam int PC_INC_DEF   = 1;
   localparam int MAX_WAIT_DEF = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      ERR   = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_wait_timer.sv
// rtl/fetch_wait_timer.sv - saturating count of FETCH cycles without an ack
// Purpose: counts enabled cycles and flags the MAX_WAIT-th consecutive one.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high reset
//   clear    in   zero the counter (takes priority over count_en)
//   count_en in   count this cycle
//   expire   out  this enabled cycle is the MAX_WAIT-th in a row
module fetch_wait_timer
   import fetch_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic expire
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (count_en && (cnt_q != CNT_SAT)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Fires during the cycle that would complete the MAX_WAIT-th miss, so the
   // owner can leave at the edge ending that cycle.
   assign expire = count_en && !clear && (cnt_q >= CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC sequencing, instruction fetch and one-entry decode buffer
// Purpose: requests instructions at pc_cur, buffers one for decode, drives the
//          next PC (increment / redirect / hold) and flags a sticky ack timeout.
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   pc_cur / pc_next   PC register output in / PC register input out (combinational)
//   mem_req/addr/ack/rdata  instruction memory read channel
//   instr_valid/instr/instr_pc/instr_ready  decode handshake
//   br_valid/br_target redirect request
//   fetch_err          sticky timeout flag
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int PC_INC   = PC_INC_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_cur,
   output logic [ADDR_W-1:0] pc_next,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              instr_ready,
   input  logic              br_valid,
   input  logic [ADDR_W-1:0] br_target,
   output logic              fetch_err
);

   fetch_state_e      state_q, state_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
   logic              instr_valid_q, instr_valid_d;
   logic              fetch_err_q, fetch_err_d;

   logic timer_clear;
   logic timer_en;
   logic timer_expire;

   fetch_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (timer_clear),
      .count_en (timer_en),
      .expire   (timer_expire)
   );

   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      fetch_err_d   = fetch_err_q;
      pc_next       = pc_cur;
      timer_clear   = 1'b0;
      timer_en      = 1'b0;

      // A redirect outranks ack and instr_ready in every live state: the
      // in-flight read and any buffered instruction are simply dropped.
      if ((state_q != ERR) && br_valid) begin
         pc_next       = br_target;
         instr_valid_d = 1'b0;
         timer_clear   = 1'b1;
         state_d       = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = FETCH;
            end
            FETCH: begin
               if (mem_ack) begin
                  instr_d       = mem_rdata;
                  instr_pc_d    = pc_cur;
                  instr_valid_d = 1'b1;
                  pc_next       = pc_cur + ADDR_W'(PC_INC);
                  timer_clear   = 1'b1;
                  state_d       = HOLD;
               end else begin
                  timer_en = 1'b1;
                  if (timer_expire) begin
                     fetch_err_d = 1'b1;
                     state_d     = ERR;
                  end
               end
            end
            HOLD: begin
               if (instr_ready) begin
                  instr_valid_d = 1'b0;
                  state_d       = FETCH;
               end
            end
            ERR: begin
               fetch_err_d   = 1'b1;
               instr_valid_d = 1'b0;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign mem_req     = (state_q == FETCH);
   assign mem_addr    = pc_cur;
   assign instr_valid = instr_valid_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign fetch_err   = fetch_err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         fetch_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         fetch_err_q   <= fetch_err_d;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [19:0] pc_reg;
   logic [19:0] pc_next;
   logic        mem_req;
   logic [19:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [19:0] instr_pc;
   logic        instr_ready = 1'b0;
   logic        br_valid = 1'b0;
   logic [19:0] br_target = '0;
   logic        fetch_err;

   int n_pass = 0;
   int n_total = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .pc_cur      (pc_reg),
      .pc_next     (pc_next),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .br_valid    (br_valid),
      .br_target   (br_target),
      .fetch_err   (fetch_err)
   );

   // PC register outside the DUT: no enable, reset with the same reset.
   always @(posedge clk or posedge reset) begin
      if (reset) pc_reg <= '0;
      else       pc_reg <= pc_next;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Behavioural model: gap = idle cycle pending, have = instruction buffered,
   // dead = timed out; otherwise a read is outstanding.
   bit          m_dead, m_gap, m_have;
   int          m_wait;
   logic [19:0] m_pc, m_bpc;
   logic [31:0] m_buf;
   logic        m_fetching;
   logic [19:0] m_next;

   function automatic logic [19:0] wrap_inc(input logic [19:0] p);
      return 20'((int'(p) + 1) % 1048576);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_dead = 0; m_gap = 1; m_have = 0; m_wait = 0;
         m_pc = '0; m_bpc = '0; m_buf = '0;
      end else if (!m_dead) begin
         if (br_valid) begin
            m_gap = 1; m_have = 0; m_wait = 0; m_pc = br_target;
         end else if (m_gap) begin
            m_gap = 0;
         end else if (m_have) begin
            if (instr_ready) m_have = 0;
         end else if (mem_ack) begin
            m_buf = mem_rdata; m_bpc = m_pc; m_have = 1; m_wait = 0;
            m_pc = wrap_inc(m_pc);
         end else begin
            m_wait++;
            if (m_wait == 15) m_dead = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         m_fetching = !m_dead && !m_gap && !m_have;
         if (m_dead)                      m_next = m_pc;
         else if (br_valid)               m_next = br_target;
         else if (m_fetching && mem_ack)  m_next = wrap_inc(m_pc);
         else                             m_next = m_pc;
         chk("pc_cur",      64'(pc_reg),      64'(m_pc));
         chk("pc_next",     64'(pc_next),     64'(m_next));
         chk("mem_req",     64'(mem_req),     64'(m_fetching));
         chk("mem_addr",    64'(mem_addr),    64'(m_pc));
         chk("instr_valid", 64'(instr_valid), 64'(m_have));
         chk("instr",       64'(instr),       64'(m_buf));
         chk("instr_pc",    64'(instr_pc),    64'(m_bpc));
         chk("fetch_err",   64'(fetch_err),   64'(m_dead));
      end
   end

   task automatic tick(input logic b, input logic [19:0] t, input logic a,
                       input logic [31:0] d, input logic r);
      @(posedge clk); #1;
      br_valid = b; br_target = t; mem_ack = a; mem_rdata = d; instr_ready = r;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; br_valid = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
      @(negedge clk);
      chk("rst_mem_req",     64'(mem_req),     64'd0);
      chk("rst_instr_valid", 64'(instr_valid), 64'd0);
      chk("rst_instr",       64'(instr),       64'd0);
      chk("rst_instr_pc",    64'(instr_pc),    64'd0);
      chk("rst_fetch_err",   64'(fetch_err),   64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
   endtask

   int ack_div;

   initial begin
      do_reset();
      chk_en = 1'b1;
      chk("idle_no_req", 64'(mem_req), 64'd0);

      // First fetch: ack on the 2nd FETCH cycle
      tick(0, 20'h0, 0, 32'h0, 0);
      chk("first_req", 64'(mem_req), 64'd1);
      chk("first_addr", 64'(mem_addr), 64'h0);
      tick(0, 20'h0, 1, 32'hDEADBEEF, 0);
      chk("first_pc_next", 64'(pc_next), 64'h1);
      tick(0, 20'h0, 0, 32'h0, 1);
      chk("first_valid", 64'(instr_valid), 64'd1);
      chk("first_instr", 64'(instr), 64'hDEADBEEF);
      chk("first_ipc", 64'(instr_pc), 64'h0);
      chk("first_pc_reg", 64'(pc_reg), 64'h1);

      // HOLD with decode stalled for 5 cycles
      tick(0, 20'h0, 1, 32'h11112222, 0);
      chk("fetch2_addr", 64'(mem_addr), 64'h1);
      for (int i = 0; i < 5; i++) begin
         tick(0, 20'h0, 0, 32'h0, 0);
         chk("stall_valid", 64'(instr_valid), 64'd1);
         chk("stall_req", 64'(mem_req), 64'd0);
         chk("stall_pc", 64'(pc_reg), 64'h2);
      end
      tick(0, 20'h0, 0, 32'h0, 1);
      tick(0, 20'h0, 0, 32'h0, 0);
      chk("after_stall_req", 64'(mem_req), 64'd1);
      chk("after_stall_addr", 64'(mem_addr), 64'h2);

      // Redirect colliding with ack
      tick(1, 20'h12340, 1, 32'hCAFEF00D, 0);
      chk("br_ack_pc_next", 64'(pc_next), 64'h12340);
      tick(0, 20'h0, 0, 32'h0, 0);
      chk("br_gap_req", 64'(mem_req), 64'd0);
      chk("br_gap_valid", 64'(instr_valid), 64'd0);
      tick(0, 20'h0, 0, 32'h0, 0);
      chk("br_new_req", 64'(mem_req), 64'd1);
      chk("br_new_addr", 64'(mem_addr), 64'h12340);
      chk("br_discard", 64'(instr), 64'h11112222);

      // PC wrap at the top of the address space
      tick(1, 20'hFFFFF, 0, 32'h0, 0);
      tick(0, 20'h0, 0, 32'h0, 0);
      tick(0, 20'h0, 1, 32'h0BADC0DE, 0);
      chk("wrap_addr", 64'(mem_addr), 64'hFFFFF);
      chk("wrap_pc_next", 64'(pc_next), 64'h0);
      tick(0, 20'h0, 0, 32'h0, 1);
      chk("wrap_ipc", 64'(instr_pc), 64'hFFFFF);
      chk("wrap_pc_reg", 64'(pc_reg), 64'h0);

      // Ack on exactly the 15th FETCH cycle is accepted
      for (int i = 0; i < 14; i++) tick(0, 20'h0, 0, 32'h0, 0);
      tick(0, 20'h0, 1, 32'h15151515, 0);
      chk("late_ack_err", 64'(fetch_err), 64'd0);
      tick(0, 20'h0, 0, 32'h0, 1);
      chk("late_ack_valid", 64'(instr_valid), 64'd1);
      chk("late_ack_instr", 64'(instr), 64'h15151515);
      chk("late_ack_err2", 64'(fetch_err), 64'd0);

      // 15 missed cycles -> ERR from cycle 16, sticky until reset
      for (int i = 0; i < 15; i++) begin
         tick(0, 20'h0, 0, 32'h0, 0);
         chk("to_req", 64'(mem_req), 64'd1);
      end
      tick(1, 20'h00055, 1, 32'h77777777, 1);
      chk("to_err", 64'(fetch_err), 64'd1);
      chk("to_req_low", 64'(mem_req), 64'd0);
      chk("to_pc_hold", 64'(pc_next), 64'h1);
      tick(0, 20'h0, 1, 32'h0, 0);
      chk("to_sticky", 64'(fetch_err), 64'd1);
      chk("to_pc_reg", 64'(pc_reg), 64'h1);
      chk("to_valid", 64'(instr_valid), 64'd0);
      do_reset();
      chk("to_cleared", 64'(fetch_err), 64'd0);

      // Randomized epochs with varying ack density and occasional resets
      for (int e = 0; e < 12; e++) begin
         case ($urandom_range(0, 2))
            0:       ack_div = 2;
            1:       ack_div = 8;
            default: ack_div = 20;
         endcase
         for (int c = 0; c < 250; c++) begin
            if ($urandom_range(0, 199) == 0) begin
               do_reset();
            end else begin
               tick($urandom_range(0, 15) == 0, 20'($urandom),
                    $urandom_range(0, ack_div - 1) == 0, $urandom,
                    $urandom_range(0, 2) != 0);
            end
         end
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
